// File: rtl/ucode_sequencer.sv
// Microcode sequencer between fetch and decode: expands MUL-class instructions into ROM micro-op sequences.
// Optional issue watchdog enabled with `define UCODE_SEQ_WATCHDOG_EN.
module ucode_sequencer #(
  parameter int          PC_W     = 4,
  parameter int          MAX_UOPS = 32,
  parameter logic [6:0]  BR_OPC   = 7'b1100001
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instr_in,
  input  logic            instr_valid,
  output logic            instr_ready,
  output logic [6:0]      mul_opcode,
  output logic [15:0]     immediate,
  output logic [3:0]      reg1,
  output logic [3:0]      reg2,
  output logic [3:0]      dest_reg,
  output logic [PC_W-1:0] ghost_pc,
  input  logic [31:0]     uop_in,
  output logic [31:0]     issue_instr,
  output logic            issue_valid,
  input  logic            issue_ready,
  input  logic            flag_valid,
  input  logic            flag_z,
  output logic            fetch_stall,
  output logic            seq_done,
  output logic            seq_err
);

  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, BRWAIT, DONE} state_t;

  state_t          state, state_nxt;
  logic [PC_W-1:0] br_off;
  logic            is_mul;
  logic            is_br;
  logic            issue_hs;
  logic            wd_hit;

  always_comb begin
    is_mul = 1'b0;
    case (instr_in[31:25])
      7'b0010000, 7'b0011000, 7'b0110000, 7'b0111000: is_mul = 1'b1;
      default:                                        is_mul = 1'b0;
    endcase
  end

  assign is_br       = (uop_in[31:25] == BR_OPC);
  assign fetch_stall = (state == FETCH) || (state == ISSUE) || (state == BRWAIT);
  assign seq_done    = (state == DONE);

  always_comb begin
    state_nxt   = state;
    issue_instr = instr_in;
    issue_valid = 1'b0;
    instr_ready = 1'b0;
    issue_hs    = 1'b0;
    case (state)
      IDLE: begin
        if (is_mul) begin
          instr_ready = 1'b1;
          if (instr_valid) state_nxt = FETCH;
        end else begin
          issue_valid = instr_valid;
          instr_ready = issue_ready;
        end
      end
      FETCH: state_nxt = ISSUE;
      ISSUE: begin
        issue_instr = uop_in;
        // An all-zero ROM word terminates the sequence and is never issued.
        if (uop_in == 32'd0) begin
          state_nxt = DONE;
        end else begin
          issue_valid = 1'b1;
          if (issue_ready) begin
            issue_hs = 1'b1;
            if (wd_hit)     state_nxt = DONE;
            else if (is_br) state_nxt = BRWAIT;
            else            state_nxt = FETCH;
          end
        end
      end
      BRWAIT: if (flag_valid) state_nxt = FETCH;
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Only the low PC_W offset bits matter: sign extension then truncation leaves them unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      ghost_pc   <= '0;
      mul_opcode <= '0;
      immediate  <= '0;
      reg1       <= '0;
      reg2       <= '0;
      dest_reg   <= '0;
      br_off     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (is_mul && instr_valid) begin
            mul_opcode <= instr_in[31:25];
            dest_reg   <= instr_in[24:21];
            reg1       <= instr_in[20:17];
            reg2       <= instr_in[16:13];
            immediate  <= instr_in[15:0];
            ghost_pc   <= '0;
          end
        end
        ISSUE: begin
          if (issue_hs) begin
            if (is_br) br_off <= uop_in[PC_W-1:0];
            else       ghost_pc <= ghost_pc + PC_W'(1);
          end
        end
        BRWAIT: begin
          if (flag_valid) ghost_pc <= flag_z ? ghost_pc + PC_W'(1) : ghost_pc + br_off;
        end
        default: ;
      endcase
    end
  end

`ifdef UCODE_SEQ_WATCHDOG_EN
  localparam int CNT_W = $clog2(MAX_UOPS + 1);

  logic [CNT_W-1:0] uop_cnt;
  logic             seq_err_q;

  // The handshake that brings the count to MAX_UOPS aborts the sequence.
  assign wd_hit  = (uop_cnt == CNT_W'(MAX_UOPS - 1));
  assign seq_err = seq_err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      uop_cnt   <= '0;
      seq_err_q <= 1'b0;
    end else begin
      if (state == IDLE && is_mul && instr_valid) uop_cnt <= '0;
      else if (issue_hs)                          uop_cnt <= uop_cnt + CNT_W'(1);
      if (issue_hs && wd_hit) seq_err_q <= 1'b1;
    end
  end
`else
  assign wd_hit  = 1'b0;
  assign seq_err = 1'b0;
`endif

endmodule
